// File: rtl/c2h_pkg.sv
// Shared types and defaults for the C2H test-pattern write path.
package c2h_pkg;

  localparam int unsigned C2H_ADDR_W = 10;
  localparam int unsigned C2H_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_WAIT  = 2'd3
  } wr_state_e;

  // Bytes per bank: the top address bit selects the bank.
  function automatic int unsigned bank_len(input int unsigned addr_w);
    return 32'd1 << (addr_w - 1);
  endfunction

endpackage

// File: rtl/ram_pingpong_ctrl.sv
// Ping-pong write scheduler: fills one RAM bank at a time from the pattern
// generator and offers each full bank to the C2H reader with req/ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | run_i low; generator gated, waiting to start
// ST_FILL  | generator enabled, each valid byte written to {wr_bank,wcnt}
// ST_CHECK | one cycle after a bank completes; decide FILL/WAIT/IDLE
// ST_WAIT  | next bank still held by the reader; stall counter runs
module ram_pingpong_ctrl
  import c2h_pkg::*;
#(
  parameter int ADDR_W  = C2H_ADDR_W,
  parameter int DATA_W  = C2H_DATA_W,
  parameter int STALL_W = 16
) (
  input  logic               clk_50m,
  input  logic               usr_rst,
  input  logic               run_i,
  input  logic               stop_i,
  input  logic               gen_vld_i,
  input  logic [DATA_W-1:0]  gen_data_i,
  output logic               gen_en_o,
  output logic               ram_wea_o,
  output logic [ADDR_W-1:0]  ram_addra_o,
  output logic [DATA_W-1:0]  ram_dina_o,
  output logic               rd_req_o,
  output logic               rd_bank_o,
  input  logic               rd_ack_i,
  output logic               busy_o,
  output logic [STALL_W-1:0] stall_cnt_o,
  output logic               err_o
);

  localparam int OFF_W = ADDR_W - 1;
  localparam int unsigned BANK_LEN = bank_len(ADDR_W);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BANK_LEN - 1);

  wr_state_e          state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [OFF_W-1:0]   wcnt_q, wcnt_d;
  logic [1:0]         full_q, full_d;
  logic               rd_bank_q, rd_bank_d;
  logic               rd_req_q, rd_req_d;
  logic               gen_en_q, gen_en_d;
  logic               wea_q, wea_d;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic [DATA_W-1:0]  dina_q, dina_d;
  logic               busy_q, busy_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;

  logic               ack_ok;
  logic               wr_fire;
  logic               bank_done;
  logic [1:0]         full_set;
  logic [1:0]         full_clr;
  logic [1:0]         full_acked;

  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wcnt_d    = wcnt_q;
    addra_d   = addra_q;
    dina_d    = dina_q;
    stall_d   = stall_q;
    full_set  = 2'b00;
    full_clr  = 2'b00;

    ack_ok    = rd_ack_i & rd_req_q;
    wr_fire   = (state_q == ST_FILL) & gen_vld_i;
    bank_done = wr_fire & (wcnt_q == LAST_OFF);

    if (bank_done) full_set[wr_bank_q] = 1'b1;
    if (ack_ok)    full_clr[rd_bank_q] = 1'b1;
    full_acked = full_q & ~full_clr;
    full_d     = full_acked | full_set;

    // A bank filled this cycle is offered one cycle later, hence full_acked.
    rd_bank_d = rd_bank_q ^ ack_ok;
    rd_req_d  = full_acked[rd_bank_d];
    err_d     = err_q | (rd_ack_i & ~rd_req_q);

    wea_d = wr_fire;
    if (wr_fire) begin
      addra_d = {wr_bank_q, wcnt_q};
      dina_d  = gen_data_i;
      wcnt_d  = wcnt_q + OFF_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = full_q[wr_bank_q] ? ST_WAIT : ST_FILL;
      end
      ST_FILL: begin
        if (bank_done) begin
          wr_bank_d = ~wr_bank_q;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!run_i)                 state_d = ST_IDLE;
        else if (full_q[wr_bank_q]) state_d = ST_WAIT;
        else                        state_d = ST_FILL;
      end
      ST_WAIT: begin
        if (stall_q != '1) stall_d = stall_q + STALL_W'(1);
        if (!run_i)                  state_d = ST_IDLE;
        else if (!full_q[wr_bank_q]) state_d = ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase

    gen_en_d = (state_d == ST_FILL);
    busy_d   = (state_d != ST_IDLE) | (|full_d);
  end

  always_ff @(posedge clk_50m) begin
    if (usr_rst || stop_i) begin
      state_q   <= ST_IDLE;
      wr_bank_q <= 1'b0;
      wcnt_q    <= '0;
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_req_q  <= 1'b0;
      gen_en_q  <= 1'b0;
      wea_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      busy_q    <= 1'b0;
      stall_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      wcnt_q    <= wcnt_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_req_q  <= rd_req_d;
      gen_en_q  <= gen_en_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      busy_q    <= busy_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
    end
  end

  assign gen_en_o    = gen_en_q;
  assign ram_wea_o   = wea_q;
  assign ram_addra_o = addra_q;
  assign ram_dina_o  = dina_q;
  assign rd_req_o    = rd_req_q;
  assign rd_bank_o   = rd_bank_q;
  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ram_pingpong_ctrl.sv
// Bench for ram_pingpong_ctrl: directed scenarios with literal expectations,
// then bursty and random traffic, all tracked by a queue-based model.
module tb_ram_pingpong_ctrl;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int STALL_W = 16;
  localparam int BLEN    = 512;
  localparam int NADDR   = 1024;

  logic               clk_50m = 1'b0;
  logic               usr_rst, run_i, stop_i, gen_vld_i, rd_ack_i;
  logic [DATA_W-1:0]  gen_data_i;
  logic               gen_en_o, ram_wea_o, rd_req_o, rd_bank_o, busy_o, err_o;
  logic [ADDR_W-1:0]  ram_addra_o;
  logic [DATA_W-1:0]  ram_dina_o;
  logic [STALL_W-1:0] stall_cnt_o;

  int n_total = 0;
  int n_bad   = 0;

  always #10 clk_50m = ~clk_50m;

  ram_pingpong_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
    .clk_50m(clk_50m), .usr_rst(usr_rst), .run_i(run_i), .stop_i(stop_i),
    .gen_vld_i(gen_vld_i), .gen_data_i(gen_data_i), .gen_en_o(gen_en_o),
    .ram_wea_o(ram_wea_o), .ram_addra_o(ram_addra_o), .ram_dina_o(ram_dina_o),
    .rd_req_o(rd_req_o), .rd_bank_o(rd_bank_o), .rd_ack_i(rd_ack_i),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  // Model: writes advance a linear position modulo the RAM size; full banks
  // sit in a FIFO in fill order; the offered bank is the parity of acks taken.
  int              m_mode;   // 0 idle, 1 filling, 2 just finished a bank, 3 waiting
  int              m_next;
  int              m_wpos;
  int              m_acks;
  int              m_stall;
  int              m_fullq[$];
  bit              m_valid = 1'b0;
  bit              m_cur_full;
  bit              m_wr;
  logic            e_gen_en, e_wea, e_req, e_bank, e_busy, e_err;
  logic [ADDR_W-1:0]  e_addr;
  logic [DATA_W-1:0]  e_din;
  logic [STALL_W-1:0] e_stall;

  always @(posedge clk_50m) begin
    if (usr_rst || stop_i) begin
      m_valid = 1'b1;
      m_mode = 0; m_wpos = 0; m_acks = 0; m_stall = 0;
      m_fullq.delete();
      e_gen_en = 0; e_wea = 0; e_req = 0; e_bank = 0; e_busy = 0; e_err = 0;
      e_addr = '0; e_din = '0; e_stall = '0;
    end else if (m_valid) begin
      m_cur_full = 1'b0;
      foreach (m_fullq[i]) if (m_fullq[i] == m_wpos / BLEN) m_cur_full = 1'b1;
      m_wr   = (m_mode == 1) && gen_vld_i;
      m_next = m_mode;
      if (m_mode == 0 && run_i) m_next = m_cur_full ? 3 : 1;
      if (m_mode == 2) m_next = !run_i ? 0 : (m_cur_full ? 3 : 1);
      if (m_mode == 3) begin
        if (m_stall < 65535) m_stall++;
        if (!run_i) m_next = 0;
        else if (!m_cur_full) m_next = 1;
      end
      if (rd_ack_i && e_req) begin
        void'(m_fullq.pop_front());
        m_acks++;
      end else if (rd_ack_i) begin
        e_err = 1'b1;
      end
      e_req  = (m_fullq.size() > 0);
      e_bank = m_acks[0];
      e_wea  = m_wr;
      if (m_wr) begin
        e_addr = ADDR_W'(m_wpos);
        e_din  = gen_data_i;
        m_wpos = (m_wpos + 1) % NADDR;
        if (m_wpos % BLEN == 0) begin
          m_fullq.push_back(int'(e_addr) / BLEN);
          m_next = 2;
        end
      end
      m_mode   = m_next;
      e_gen_en = (m_mode == 1);
      e_busy   = (m_mode != 0) || (m_fullq.size() > 0);
      e_stall  = STALL_W'(m_stall);
    end
  end

  logic [39:0] act_v, exp_v;
  always @(posedge clk_50m) begin
    #1;
    if (m_valid) begin
      act_v = {gen_en_o, ram_wea_o, ram_addra_o, ram_dina_o, rd_req_o, rd_bank_o,
               busy_o, stall_cnt_o, err_o};
      exp_v = {e_gen_en, e_wea, e_addr, e_din, e_req, e_bank, e_busy, e_stall, e_err};
      n_total++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t {gen_en,wea,addr,din,req,bank,busy,stall,err} dut=%h model=%h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int nwr = 0;
  bit dir_data = 1'b1;

  task automatic step();
    @(negedge clk_50m);
    if (ram_wea_o) nwr++;
    if (dir_data) gen_data_i = nwr[7:0];
  endtask

  task automatic wait_write(input int addr, input int budget, input string name);
    int i;
    i = 0;
    while (!(ram_wea_o && int'(ram_addra_o) == addr) && i < budget) begin
      step();
      i++;
    end
    chk(name, 32'(ram_wea_o && int'(ram_addra_o) == addr), 32'd1);
  endtask

  task automatic zero_outputs(input string name);
    chk(name, 32'({gen_en_o, ram_wea_o, ram_addra_o, ram_dina_o, rd_req_o, rd_bank_o,
                   busy_o, err_o}), 32'd0);
    chk({name, "_stall"}, 32'(stall_cnt_o), 32'd0);
  endtask

  task automatic pulse_ack();
    rd_ack_i = 1'b1;
    step();
    rd_ack_i = 1'b0;
  endtask

  initial begin
    int cyc;
    usr_rst = 1; run_i = 0; stop_i = 0; gen_vld_i = 0; rd_ack_i = 0; gen_data_i = '0;
    repeat (3) step();
    zero_outputs("reset");
    usr_rst = 0;

    // Continuous valid, incrementing data.
    nwr = 0; gen_data_i = 8'd0; run_i = 1; gen_vld_i = 1;
    cyc = 0;
    while (!ram_wea_o && cyc < 10) begin step(); cyc++; end
    chk("first_write_latency", 32'(cyc), 32'd2);
    chk("first_write_addr", 32'(ram_addra_o), 32'd0);
    chk("first_write_data", 32'(ram_dina_o), 32'd0);
    wait_write(511, 1000, "reach_addr_511");
    chk("addr_511_data", 32'(ram_dina_o), 32'hff);
    chk("req_before_fill_seen", 32'(rd_req_o), 32'd0);
    step();
    chk("req_after_bank0", 32'({ram_wea_o, rd_req_o, rd_bank_o}), 32'b010);
    step();
    chk("resume_at_512", 32'({ram_wea_o, ram_addra_o}), 32'h600);
    chk("data_at_512", 32'(ram_dina_o), 32'd0);

    // No acks: both banks fill, then stall.
    wait_write(1023, 1000, "reach_addr_1023");
    cyc = 0;
    while (stall_cnt_o != 16'd1 && cyc < 20) begin step(); cyc++; end
    chk("stall_starts", 32'(stall_cnt_o), 32'd1);
    repeat (3) step();
    chk("stall_counts", 32'(stall_cnt_o), 32'd4);
    chk("wait_gen_en", 32'({gen_en_o, ram_wea_o, rd_req_o, rd_bank_o}), 32'b0010);

    pulse_ack();
    cyc = 0;
    while (!ram_wea_o && cyc < 10) begin step(); cyc++; end
    chk("refill_addr0", 32'({ram_wea_o, ram_addra_o}), 32'h400);
    chk("offer_bank1", 32'({rd_req_o, rd_bank_o}), 32'b11);

    pulse_ack();
    step();
    chk("after_ack_bank1", 32'({rd_req_o, rd_bank_o}), 32'b00);

    // Drop run mid-bank: bank is still completed.
    wait_write(100, 200, "reach_addr_100");
    run_i = 0;
    wait_write(511, 1000, "complete_bank_after_run_drop");
    repeat (3) step();
    chk("idle_one_full", 32'({gen_en_o, ram_wea_o, rd_req_o, rd_bank_o, busy_o}), 32'b00101);

    pulse_ack();
    step();
    chk("all_drained", 32'({rd_req_o, busy_o, err_o}), 32'b000);
    pulse_ack();
    step();
    chk("spurious_ack_err", 32'(err_o), 32'd1);
    repeat (5) step();
    chk("err_sticky", 32'({err_o, busy_o, rd_req_o, rd_bank_o}), 32'b1001);

    // Stop mid-fill with one bank full.
    run_i = 1;
    wait_write(1023, 1200, "fill_bank1_for_stop");
    wait_write(50, 200, "reach_addr_50");
    chk("one_full_before_stop", 32'({rd_req_o, rd_bank_o}), 32'b11);
    stop_i = 1;
    step();
    stop_i = 0;
    zero_outputs("after_stop");
    cyc = 0;
    while (!ram_wea_o && cyc < 10) begin step(); cyc++; end
    chk("restart_addr0", 32'({ram_wea_o, ram_addra_o}), 32'h400);

    // Bursty valid, one in three cycles, lazy random acks.
    dir_data = 1'b0;
    usr_rst = 1; step(); usr_rst = 0;
    for (int c = 0; c < 6000; c++) begin
      gen_vld_i  = (c % 3 == 0);
      gen_data_i = DATA_W'($urandom);
      rd_ack_i   = rd_req_o && ($urandom_range(0, 15) == 0);
      step();
    end

    // Fully random traffic with occasional flushes.
    for (int c = 0; c < 25000; c++) begin
      if ($urandom_range(0, 499) == 0) run_i = ~run_i;
      gen_vld_i  = ($urandom_range(0, 3) != 0);
      gen_data_i = DATA_W'($urandom);
      rd_ack_i   = ($urandom_range(0, 9) == 0);
      stop_i     = ($urandom_range(0, 5999) == 0);
      usr_rst    = ($urandom_range(0, 8999) == 0);
      step();
    end
    stop_i = 0; usr_rst = 0; rd_ack_i = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_pingpong_ctrl.md
Name: ram_pingpong_ctrl

Overview:
Write-side scheduler for the C2H test-pattern path. It gates the byte pattern generator and writes its stream into a two-bank (ping-pong) simple dual-port RAM, one full bank at a time. It then hands each full bank to the C2H DMA reader with a req/ack handshake. It sits between the pattern generator, the RAM write port and the C2H read engine, and counts stall cycles for debug.

Parameters:
ADDR_W, 10, RAM address width; each bank holds BANK_LEN = 2**(ADDR_W-1) bytes.
DATA_W, 8, generator/RAM data width.
STALL_W, 16, width of stall counter.

Ports:
clk_50m  in  1  block clock, 50 MHz.
usr_rst  in  1  synchronous reset, active-high.
run_i  in  1  level; enable filling banks.
stop_i  in  1  pulse; synchronous flush, same effect as usr_rst (tie to s0_axis_c2h_rst_i).
gen_vld_i  in  1  generator data valid this cycle.
gen_data_i  in  DATA_W  generator data.
gen_en_o  out  1  enable to pattern generator.
ram_wea_o  out  1  RAM port-A write enable.
ram_addra_o  out  ADDR_W  RAM port-A address, {bank, offset}.
ram_dina_o  out  DATA_W  RAM port-A data.
rd_req_o  out  1  a full bank is available to the reader.
rd_bank_o  out  1  bank index offered to the reader.
rd_ack_i  in  1  one-cycle pulse; reader has finished bank rd_bank_o.
busy_o  out  1  state != IDLE or any bank full.
stall_cnt_o  out  STALL_W  cycles spent in WAIT, saturating.
err_o  out  1  sticky; set if rd_ack_i arrives while rd_req_o=0.

Behaviour:
- Reset (usr_rst or stop_i): all outputs 0, full[1:0]=0, wr_bank=0, rd_bank=0, wcnt=0, state=IDLE. stop_i has priority over every other event in the same cycle.
- Writer FSM states: IDLE, FILL, CHECK, WAIT.
- IDLE:
  - gen_en_o=0.
  - If run_i=1 and full[wr_bank]=0, go to FILL.
  - If run_i=1 and full[wr_bank]=1, go to WAIT.
- FILL:
  - gen_en_o=1.
  - Each cycle with gen_vld_i=1, register one write: ram_wea_o=1, ram_addra_o={wr_bank,wcnt}, ram_dina_o=gen_data_i, then wcnt++.
  - Latency: 1 cycle from gen_vld_i to ram_wea_o. No gen_vld_i means ram_wea_o=0 and wcnt holds.
  - On the write with wcnt==BANK_LEN-1: set full[wr_bank], toggle wr_bank, wcnt wraps to 0, go to CHECK. gen_en_o drops in CHECK.
- CHECK (1 cycle, gen_en_o=0):
  - If run_i=0, go to IDLE.
  - Else if full[wr_bank]=1, go to WAIT.
  - Else go to FILL.
- WAIT:
  - gen_en_o=0; stall_cnt_o increments each cycle, saturating at all-ones.
  - Go to FILL when full[wr_bank] clears and run_i=1.
  - Go to IDLE if run_i=0.
- run_i deasserted mid-FILL: the current bank is completed (no partial banks). run_i is sampled again only in CHECK, IDLE and WAIT.
- Any gen_vld_i outside FILL is ignored (no write).
- Reader side:
  - rd_req_o = full[rd_bank], registered, so it rises 1 cycle after the bank fills.
  - rd_bank_o = rd_bank.
  - rd_ack_i with rd_req_o=1: clear full[rd_bank], toggle rd_bank. rd_req_o drops the next cycle, or stays high if the other bank is already full, in which case rd_bank_o changes.
  - rd_ack_i with rd_req_o=0: ignored, err_o set (cleared only by reset/stop).
- Set and clear of full[] in the same cycle always hit different banks (writer only fills a non-full bank). Both updates apply.
- Banks are delivered strictly in fill order: 0, 1, 0, 1, and so on.

Decomposition:
- Shared package c2h_pkg holds:
  - writer state enum (IDLE, FILL, CHECK, WAIT);
  - defaults ADDR_W=10, DATA_W=8;
  - helper function bank_len(addr_w).
- No sub-module needed. Optionally a small pp_bank_tracker (full flags + rd pointer + req/ack logic), instantiated once.

Test Plan:
- Reset, then run_i=1 with gen_vld_i always 1 and incrementing data:
  - first ram_wea_o 1 cycle after the first valid; addresses 0..511 carry data 0..255,0..255;
  - rd_req_o=1 with rd_bank_o=0 one cycle after the address-511 write;
  - FILL resumes at address 512 after the 1 CHECK cycle.
- No rd_ack_i: both banks fill, then state=WAIT, gen_en_o=0, stall_cnt_o counts 1,2,3,…. Ack bank 0, then FILL restarts at address 0 and rd_bank_o becomes 1 with rd_req_o still 1.
- run_i dropped at wcnt=100: writes continue to wcnt=511 (gated by gen_vld_i), then CHECK and IDLE; full=2'b01.
- stop_i pulsed mid-FILL with one bank full: next cycle all outputs 0, full=0, next fill starts at address 0.
- rd_ack_i pulsed while rd_req_o=0: err_o=1 and stays 1; full flags unchanged.
- Bursty gen_vld_i (1 of every 3 cycles): exactly 512 writes per bank, addresses contiguous, no write in cycles without valid.
